seq_divider: RTL and testbench

- Multi-cycle unsigned restoring divider: one quotient bit per clock.
- Sits directly downstream of the iteration-control state machine, in the divide step of the series datapath.
- Consumes the controller's active-low enable resetD and returns the completion flag donee, which the controller waits on in its div state.
- Quotient and remainder feed the following multiplier stage.

---
 rtl/seq_divider.sv | 99 +++++++++
 tb/tb_seq_divider.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider producing one quotient bit per clock.
// Results are registered and held until the next completed operation.
module seq_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             resetD,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             donee,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] work_q;
  logic [WIDTH-1:0] work_d;
  logic [WIDTH:0]   work_r;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   next_r;
  logic [WIDTH-1:0] next_q;

  // One restoring step: shift in the next dividend bit, keep the difference if it did not borrow.
  always_comb begin
    shifted = {work_r[WIDTH-1:0], work_q[WIDTH-1]};
    trial   = shifted - {1'b0, work_d};
    next_r  = trial[WIDTH] ? shifted : trial;
    next_q  = {work_q[WIDTH-2:0], ~trial[WIDTH]};
  end

  // donee is registered alongside state so it always equals (state == DONE).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      work_q      <= '0;
      work_d      <= '0;
      work_r      <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      donee       <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          donee <= 1'b0;
          if (!resetD) begin
            work_q <= dividend;
            work_d <= divisor;
            work_r <= '0;
            cnt    <= CW'(WIDTH);
            state  <= BUSY;
          end
        end
        BUSY: begin
          if (resetD) begin
            state <= IDLE;
            donee <= 1'b0;
          end else begin
            work_q <= next_q;
            work_r <= next_r;
            cnt    <= cnt - 1'b1;
            if (cnt == CW'(1)) begin
              quotient    <= next_q;
              remainder   <= next_r[WIDTH-1:0];
              div_by_zero <= (work_d == '0);
              donee       <= 1'b1;
              state       <= DONE;
            end else begin
              donee <= 1'b0;
            end
          end
        end
        DONE: begin
          if (resetD) begin
            state <= IDLE;
            donee <= 1'b0;
          end else begin
            donee <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          donee <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: per-cycle reference model plus directed literal checks.
module tb_seq_divider;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             resetD = 1'b1;
  logic [WIDTH-1:0] dividend = '0;
  logic [WIDTH-1:0] divisor = '0;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             donee;
  logic             div_by_zero;

  int vectors = 0;
  int miscompares = 0;

  seq_divider #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .resetD     (resetD),
    .dividend   (dividend),
    .divisor    (divisor),
    .quotient   (quotient),
    .remainder  (remainder),
    .donee      (donee),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Reference model: an operation is a pending arithmetic result released WIDTH+1 edges after load.
  logic             m_busy = 1'b0;
  logic             m_done = 1'b0;
  int               m_left = 0;
  logic [WIDTH-1:0] p_q = '0, p_r = '0;
  logic             p_z = 1'b0;
  logic [WIDTH-1:0] e_q = '0, e_r = '0;
  logic             e_z = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_left <= 0;
      e_q <= '0; e_r <= '0; e_z <= 1'b0;
    end else if (m_busy) begin
      if (resetD) m_busy <= 1'b0;
      else if (m_left == 1) begin
        m_busy <= 1'b0; m_done <= 1'b1;
        e_q <= p_q; e_r <= p_r; e_z <= p_z;
      end else m_left <= m_left - 1;
    end else if (m_done) begin
      if (resetD) m_done <= 1'b0;
    end else if (!resetD) begin
      m_busy <= 1'b1;
      m_left <= WIDTH;
      p_z    <= (divisor == '0);
      p_q    <= (divisor == '0) ? '1 : dividend / divisor;
      p_r    <= (divisor == '0) ? dividend : dividend % divisor;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("cyc_donee", 32'(donee), 32'(m_done));
    chk("cyc_quotient", 32'(quotient), 32'(e_q));
    chk("cyc_remainder", 32'(remainder), 32'(e_r));
    chk("cyc_dbz", 32'(div_by_zero), 32'(e_z));
  end

  task automatic start_op(input logic [WIDTH-1:0] n, input logic [WIDTH-1:0] d);
    @(negedge clk);
    dividend = n;
    divisor  = d;
    resetD   = 1'b0;
  endtask

  // Counts edges from the load edge until donee; expects done after edge 17.
  task automatic wait_done(input int first, output int edges);
    edges = first;
    while (!donee && edges < 40) begin
      @(posedge clk);
      edges++;
      #1;
    end
  endtask

  task automatic run_op(input logic [WIDTH-1:0] n, input logic [WIDTH-1:0] d, input string nm);
    int edges;
    start_op(n, d);
    @(negedge clk);
    dividend = 16'($urandom);
    divisor  = 16'($urandom);
    wait_done(1, edges);
    chk({nm, "_latency"}, 32'(edges), 32'(WIDTH + 1));
  endtask

  task automatic release_op();
    @(negedge clk);
    resetD = 1'b1;
  endtask

  initial begin
    int edges;
    logic [WIDTH-1:0] n, d;
    #1 reset = 1'b1;
    #12 reset = 1'b0;
    @(negedge clk);
    chk("rst_q", 32'(quotient), 32'h0);
    chk("rst_r", 32'(remainder), 32'h0);
    chk("rst_donee", 32'(donee), 32'h0);
    chk("rst_dbz", 32'(div_by_zero), 32'h0);

    run_op(16'd100, 16'd7, "t100_7");
    chk("t100_7_q", 32'(quotient), 32'd14);
    chk("t100_7_r", 32'(remainder), 32'd2);
    chk("t100_7_dbz", 32'(div_by_zero), 32'd0);
    chk("model_q_100_7", 32'(e_q), 32'd14);
    repeat (10) @(negedge clk);
    chk("hold_donee", 32'(donee), 32'd1);
    chk("hold_q", 32'(quotient), 32'd14);
    chk("hold_r", 32'(remainder), 32'd2);
    release_op();

    run_op(16'hFFFF, 16'd1, "tffff_1");
    chk("tffff_1_q", 32'(quotient), 32'hFFFF);
    chk("tffff_1_r", 32'(remainder), 32'd0);
    release_op();
    run_op(16'd5, 16'd9, "t5_9");
    chk("t5_9_q", 32'(quotient), 32'd0);
    chk("t5_9_r", 32'(remainder), 32'd5);
    release_op();

    run_op(16'd1234, 16'd0, "t1234_0");
    chk("t1234_0_q", 32'(quotient), 32'hFFFF);
    chk("t1234_0_r", 32'(remainder), 32'd1234);
    chk("t1234_0_dbz", 32'(div_by_zero), 32'd1);
    chk("model_r_1234_0", 32'(e_r), 32'd1234);
    release_op();

    start_op(16'd1000, 16'd3);
    repeat (6) @(negedge clk);
    resetD = 1'b1;
    repeat (20) begin
      @(negedge clk);
      chk("abort_donee", 32'(donee), 32'd0);
    end
    chk("abort_q_kept", 32'(quotient), 32'hFFFF);
    chk("abort_r_kept", 32'(remainder), 32'd1234);
    chk("abort_dbz_kept", 32'(div_by_zero), 32'd1);
    run_op(16'd1000, 16'd3, "t1000_3");
    chk("t1000_3_q", 32'(quotient), 32'd333);
    chk("t1000_3_r", 32'(remainder), 32'd1);
    chk("t1000_3_dbz", 32'(div_by_zero), 32'd0);
    release_op();

    // Asynchronous reset between edges while busy.
    start_op(16'd500, 16'd7);
    repeat (4) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_q", 32'(quotient), 32'h0);
    chk("arst_r", 32'(remainder), 32'h0);
    chk("arst_donee", 32'(donee), 32'h0);
    chk("arst_dbz", 32'(div_by_zero), 32'h0);
    #1 reset = 1'b0;
    wait_done(0, edges);
    chk("arst_restart_latency", 32'(edges), 32'(WIDTH + 1));
    chk("arst_restart_q", 32'(quotient), 32'd71);
    chk("arst_restart_r", 32'(remainder), 32'd3);
    release_op();

    for (int i = 0; i < 1000; i++) begin
      case ($urandom_range(0, 4))
        0: begin n = 16'($urandom); d = 16'($urandom); end
        1: begin n = 16'($urandom_range(0, 1000)); d = n + 16'($urandom_range(1, 1000)); end
        2: begin n = 16'($urandom); d = 16'(1) << $urandom_range(0, 15); end
        3: begin n = 16'(1) << $urandom_range(0, 15); d = 16'($urandom_range(1, 300)); end
        default: begin n = 16'($urandom); d = 16'($urandom_range(0, 3)); end
      endcase
      run_op(n, d, "rnd");
      chk("rnd_dbz", 32'(div_by_zero), 32'(d == '0));
      if (d != '0) begin
        chk("rnd_inv", 32'(quotient) * 32'(d) + 32'(remainder), 32'(n));
        chk("rnd_r_lt_d", 32'(remainder < d), 32'd1);
      end else begin
        chk("rnd_dbz_q", 32'(quotient), 32'hFFFF);
        chk("rnd_dbz_r", 32'(remainder), 32'(n));
      end
      release_op();
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
